// File: rtl/switch_change_detector.sv
// Multi-channel switch change detector: synchronise, debounce and report accepted
// transitions as one-cycle pulses plus a sticky, acknowledgeable event mask.
module switch_change_detector #(
    parameter int unsigned N               = 8,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] sw_in,
    output logic [N-1:0] sw_state,
    output logic [N-1:0] change_pulse,
    output logic [N-1:0] rise_pulse,
    output logic [N-1:0] fall_pulse,
    output logic         ready,
    output logic         event_valid,
    output logic [N-1:0] event_mask,
    input  logic         event_ack
);

    localparam int unsigned CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PRIME_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES);

    typedef enum logic {
        PRIME,
        ARMED
    } stateT;

    stateT               state;
    stateT               stateNext;
    logic [PRIME_W-1:0]  primeCnt;
    logic [PRIME_W-1:0]  primeCntNext;
    logic                readyNext;

    logic [N-1:0]        syncChain [SYNC_STAGES];
    logic [N-1:0]        syncOut;
    logic [CNT_W-1:0]    cnt       [N];
    logic [CNT_W-1:0]    cntNext   [N];
    logic [N-1:0]        swStateNext;
    logic [N-1:0]        changeNext;
    logic [N-1:0]        riseNext;
    logic [N-1:0]        fallNext;
    logic [N-1:0]        maskNext;

    assign syncOut     = syncChain[SYNC_STAGES-1];
    assign event_valid = |event_mask;

    // Metastability synchroniser, one chain per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                syncChain[s] <= '0;
            end
        end else begin
            syncChain[0] <= sw_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                syncChain[s] <= syncChain[s-1];
            end
        end
    end

    // State, debounce counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= PRIME;
            primeCnt     <= '0;
            ready        <= 1'b0;
            sw_state     <= '0;
            change_pulse <= '0;
            rise_pulse   <= '0;
            fall_pulse   <= '0;
            event_mask   <= '0;
            for (int unsigned c = 0; c < N; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            state        <= stateNext;
            primeCnt     <= primeCntNext;
            ready        <= readyNext;
            sw_state     <= swStateNext;
            change_pulse <= changeNext;
            rise_pulse   <= riseNext;
            fall_pulse   <= fallNext;
            event_mask   <= maskNext;
            for (int unsigned c = 0; c < N; c++) begin
                cnt[c] <= cntNext[c];
            end
        end
    end

    always_comb begin
        stateNext    = state;
        primeCntNext = primeCnt;
        readyNext    = ready;
        swStateNext  = sw_state;
        changeNext   = '0;
        for (int unsigned c = 0; c < N; c++) begin
            cntNext[c] = '0;
        end

        unique case (state)
            // Load power-up levels silently until the synchronisers are full
            PRIME: begin
                swStateNext = syncOut;
                if (primeCnt == PRIME_LAST) begin
                    stateNext = ARMED;
                    readyNext = 1'b1;
                end else begin
                    primeCntNext = primeCnt + PRIME_W'(1);
                end
            end
            ARMED: begin
                for (int unsigned c = 0; c < N; c++) begin
                    if (syncOut[c] == sw_state[c]) begin
                        cntNext[c] = '0;
                    end else if (cnt[c] == CNT_LAST) begin
                        swStateNext[c] = syncOut[c];
                        changeNext[c]  = 1'b1;
                    end else begin
                        cntNext[c] = cnt[c] + CNT_W'(1);
                    end
                end
            end
            default: begin
                stateNext = PRIME;
            end
        endcase

        riseNext = changeNext & swStateNext;
        fallNext = changeNext & ~swStateNext;
        // A pulse coincident with the ack survives the clear
        maskNext = (event_ack ? '0 : event_mask) | changeNext;
    end

endmodule

// File: tb/tb_switch_change_detector.sv
// Scoreboard bench for switch_change_detector: stimulus queues expected pulses,
// a negedge monitor pops and compares them whenever change_pulse is non-zero.
module tb_switch_change_detector;

    localparam int unsigned N   = 4;
    localparam int unsigned SS  = 2;
    localparam int unsigned DB  = 4;
    localparam int unsigned LAT = SS + DB;

    logic         clk = 1'b0;
    logic         rst;
    logic         event_ack;
    logic [N-1:0] sw_in;
    logic [N-1:0] sw_state;
    logic [N-1:0] change_pulse;
    logic [N-1:0] rise_pulse;
    logic [N-1:0] fall_pulse;
    logic         ready;
    logic         event_valid;
    logic [N-1:0] event_mask;

    typedef struct {
        int unsigned  edgeNo;
        logic [N-1:0] change;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] state;
        logic [N-1:0] mask;
    } expT;

    expT         expQ[$];
    int          checks  = 0;
    int          errors  = 0;
    int unsigned edgeCnt = 0;

    switch_change_detector #(
        .N              (N),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_in       (sw_in),
        .sw_state    (sw_state),
        .change_pulse(change_pulse),
        .rise_pulse  (rise_pulse),
        .fall_pulse  (fall_pulse),
        .ready       (ready),
        .event_valid (event_valid),
        .event_mask  (event_mask),
        .event_ack   (event_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input int unsigned offs, input logic [N-1:0] ch, input logic [N-1:0] ri,
                           input logic [N-1:0] fa, input logic [N-1:0] st, input logic [N-1:0] mk);
        expT e;
        e.edgeNo = edgeCnt + offs;
        e.change = ch;
        e.rise   = ri;
        e.fall   = fa;
        e.state  = st;
        e.mask   = mk;
        expQ.push_back(e);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_sw_state"}, 32'(sw_state), 32'h0);
        check({tag, "_change"}, 32'(change_pulse), 32'h0);
        check({tag, "_rise"}, 32'(rise_pulse), 32'h0);
        check({tag, "_fall"}, 32'(fall_pulse), 32'h0);
        check({tag, "_ready"}, 32'(ready), 32'h0);
        check({tag, "_mask"}, 32'(event_mask), 32'h0);
        check({tag, "_valid"}, 32'(event_valid), 32'h0);
    endtask

    task automatic ackPulse();
        event_ack = 1'b1;
        tick(1);
        event_ack = 1'b0;
    endtask

    // Monitor: every presented pulse must match the head of the scoreboard
    always @(negedge clk) begin
        expT e;
        if (change_pulse !== '0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: change_pulse=%b at edge %0d, none expected",
                         change_pulse, edgeCnt);
            end else begin
                e = expQ.pop_front();
                check("pulse_edge", 32'(edgeCnt), 32'(e.edgeNo));
                check("pulse_change", 32'(change_pulse), 32'(e.change));
                check("pulse_rise", 32'(rise_pulse), 32'(e.rise));
                check("pulse_fall", 32'(fall_pulse), 32'(e.fall));
                check("pulse_sw_state", 32'(sw_state), 32'(e.state));
                check("pulse_mask", 32'(event_mask), 32'(e.mask));
                check("pulse_valid", 32'(event_valid), 32'(|e.mask));
            end
        end
        if (ready === 1'b0) begin
            check("priming_mask", 32'(event_mask), 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        event_ack = 1'b0;
        sw_in     = 4'b1010;
        #1;
        checkAllZero("reset");
        tick(3);
        rst = 1'b0;

        // Priming: ready on the third edge with the power-up levels captured
        tick(2);
        check("prime_ready_early", 32'(ready), 32'h0);
        tick(1);
        check("prime_ready", 32'(ready), 32'h1);
        check("prime_sw_state", 32'(sw_state), 32'b1010);
        check("prime_mask", 32'(event_mask), 32'h0);
        tick(3);

        // Single rise on channel 0
        sw_in = 4'b1011;
        pushExp(LAT, 4'b0001, 4'b0001, 4'b0000, 4'b1011, 4'b0001);
        tick(LAT + 2);
        check("rise0_mask", 32'(event_mask), 32'b0001);
        check("rise0_valid", 32'(event_valid), 32'h1);
        check("rise0_pulse_gone", 32'(change_pulse), 32'h0);
        ackPulse();
        check("ack0_mask", 32'(event_mask), 32'h0);
        check("ack0_valid", 32'(event_valid), 32'h0);

        // 3-cycle glitch on channel 1 is rejected
        sw_in = 4'b1001;
        tick(3);
        sw_in = 4'b1011;
        tick(8);
        check("glitch_sw_state", 32'(sw_state), 32'b1011);
        check("glitch_mask", 32'(event_mask), 32'h0);

        // 4-cycle excursion is accepted: fall, then rise DB edges later
        sw_in = 4'b1001;
        pushExp(LAT, 4'b0010, 4'b0000, 4'b0010, 4'b1001, 4'b0010);
        pushExp(LAT + DB, 4'b0010, 4'b0010, 4'b0000, 4'b1011, 4'b0010);
        tick(4);
        sw_in = 4'b1011;
        tick(10);
        check("pulse4_sw_state", 32'(sw_state), 32'b1011);
        check("pulse4_mask", 32'(event_mask), 32'b0010);
        ackPulse();
        check("ack1_mask", 32'(event_mask), 32'h0);

        // Channels 2 and 3 change together
        sw_in = 4'b0111;
        pushExp(LAT, 4'b1100, 4'b0100, 4'b1000, 4'b0111, 4'b1100);
        tick(LAT + 2);
        check("dual_mask", 32'(event_mask), 32'b1100);
        ackPulse();
        check("dual_ack_mask", 32'(event_mask), 32'h0);
        ackPulse();
        check("idle_ack_mask", 32'(event_mask), 32'h0);

        // Ack coincident with a new pulse on channel 0 while mask is 0010
        sw_in = 4'b0101;
        pushExp(LAT, 4'b0010, 4'b0000, 4'b0010, 4'b0101, 4'b0010);
        tick(LAT + 2);
        check("pre_coinc_mask", 32'(event_mask), 32'b0010);
        sw_in = 4'b0100;
        pushExp(LAT, 4'b0001, 4'b0000, 4'b0001, 4'b0100, 4'b0001);
        tick(LAT - 1);
        ackPulse();
        check("coinc_mask", 32'(event_mask), 32'b0001);
        tick(2);

        // Reset mid-debounce on channel 1, then re-prime without a pulse
        sw_in = 4'b0110;
        tick(4);
        rst = 1'b1;
        #1;
        checkAllZero("midrst");
        tick(2);
        rst = 1'b0;
        tick(2);
        check("reprime_ready_early", 32'(ready), 32'h0);
        tick(1);
        check("reprime_ready", 32'(ready), 32'h1);
        check("reprime_sw_state", 32'(sw_state), 32'b0110);
        check("reprime_mask", 32'(event_mask), 32'h0);
        tick(10);
        check("reprime_quiet_mask", 32'(event_mask), 32'h0);

        check("scoreboard_drained", 32'(expQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
